// File: rtl/fetch_redirect_unit.sv
// Instruction fetch front end: keeps one imem request in flight, buffers a word
// across decode stalls, and redirects with flush on taken branches/jumps.
module fetch_redirect_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        branch_jump_signal_in,
    input  logic [63:0] target_pc_in,
    input  logic        stall_in,
    output logic        imem_req_out,
    output logic [63:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] instr_out,
    output logic [63:0] instr_pc_out,
    output logic        instr_valid_out,
    output logic        flush_out,
    output logic        misaligned_out
);

    typedef enum logic [1:0] {IDLE, REQ, BUF, DISCARD} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] disc_addr_q, disc_addr_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [63:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        flush_q, flush_d;
    logic        misaligned_q, misaligned_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            disc_addr_q   <= RESET_PC;
            buf_data_q    <= '0;
            buf_pc_q      <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            disc_addr_q   <= disc_addr_d;
            buf_data_q    <= buf_data_d;
            buf_pc_q      <= buf_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            flush_q       <= flush_d;
            misaligned_q  <= misaligned_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        disc_addr_d   = disc_addr_q;
        buf_data_d    = buf_data_q;
        buf_pc_d      = buf_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        flush_d       = 1'b0;
        misaligned_d  = 1'b0;

        if (branch_jump_signal_in) begin
            pc_d          = {target_pc_in[63:2], 2'b00};
            instr_valid_d = 1'b0;
            flush_d       = 1'b1;
            misaligned_d  = |target_pc_in[1:0];
            case (state_q)
                REQ: begin
                    // Old request still in flight: remember its address so the
                    // bus stays stable until its ack is swallowed.
                    if (imem_ack_in) begin
                        state_d = REQ;
                    end else begin
                        state_d     = DISCARD;
                        disc_addr_d = pc_q;
                    end
                end
                DISCARD: state_d = imem_ack_in ? REQ : DISCARD;
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_ack_in) begin
                        pc_d = pc_q + 64'd4;
                        if (stall_in) begin
                            buf_data_d = imem_data_in;
                            buf_pc_d   = pc_q;
                            state_d    = BUF;
                        end else begin
                            instr_d       = imem_data_in;
                            instr_pc_d    = pc_q;
                            instr_valid_d = 1'b1;
                        end
                    end else if (!stall_in) begin
                        instr_valid_d = 1'b0;
                    end
                end
                BUF: begin
                    if (!stall_in) begin
                        instr_d       = buf_data_q;
                        instr_pc_d    = buf_pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = REQ;
                    end
                end
                DISCARD: begin
                    if (imem_ack_in) state_d = REQ;
                end
                default: state_d = REQ;
            endcase
        end
    end

    assign imem_req_out    = (state_q == REQ) || (state_q == DISCARD);
    assign imem_addr_out   = (state_q == DISCARD) ? disc_addr_q : pc_q;
    assign instr_out       = instr_q;
    assign instr_pc_out    = instr_pc_q;
    assign instr_valid_out = instr_valid_q;
    assign flush_out       = flush_q;
    assign misaligned_out  = misaligned_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed cycle-by-cycle vectors for fetch_redirect_unit plus an async reset sequence.
module tb_fetch_redirect_unit;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        branch_jump_signal_in;
    logic [63:0] target_pc_in;
    logic        stall_in;
    logic        imem_req_out;
    logic [63:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_data_in;
    logic [31:0] instr_out;
    logic [63:0] instr_pc_out;
    logic        instr_valid_out;
    logic        flush_out;
    logic        misaligned_out;

    int checks = 0;
    int errors = 0;

    fetch_redirect_unit #(.RESET_PC(64'h1000)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .branch_jump_signal_in(branch_jump_signal_in), .target_pc_in(target_pc_in),
        .stall_in(stall_in), .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_ack_in(imem_ack_in), .imem_data_in(imem_data_in), .instr_out(instr_out),
        .instr_pc_out(instr_pc_out), .instr_valid_out(instr_valid_out),
        .flush_out(flush_out), .misaligned_out(misaligned_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        br;
        logic [63:0] tgt;
        logic        stall;
        logic        ack;
        logic [31:0] data;
        logic        req;
        logic [63:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [63:0] ipc;
        logic        flush;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic br, input logic [63:0] tgt, input logic stall,
                     input logic ack, input logic [31:0] data, input logic req,
                     input logic [63:0] addr, input logic vld, input logic [31:0] instr,
                     input logic [63:0] ipc, input logic flush, input logic mis);
        vec_t e;
        e.br = br; e.tgt = tgt; e.stall = stall; e.ack = ack; e.data = data;
        e.req = req; e.addr = addr; e.vld = vld; e.instr = instr; e.ipc = ipc;
        e.flush = flush; e.mis = mis;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic req, input logic [63:0] addr,
                         input logic vld, input logic [31:0] instr, input logic [63:0] ipc,
                         input logic flush, input logic mis);
        logic [194:0] act, exp;
        act = {imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out, flush_out, misaligned_out};
        exp = {req, addr, vld, instr, ipc, flush, mis};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got req=%0b addr=%h vld=%0b instr=%h pc=%h flush=%0b mis=%0b, want req=%0b addr=%h vld=%0b instr=%h pc=%h flush=%0b mis=%0b",
                     name, imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out,
                     flush_out, misaligned_out, req, addr, vld, instr, ipc, flush, mis);
        end
    endtask

    initial begin
        //  br tgt                     st ack data          req addr                   vld instr         ipc                    fl mis
        v(0, 64'h0,                    0, 0, 32'h0,         1, 64'h1000,               0, 32'h0,         64'h0,                 0, 0); // IDLE->REQ
        v(0, 64'h0,                    0, 1, 32'hAAAA0001,  1, 64'h1004,               1, 32'hAAAA0001,  64'h1000,              0, 0);
        v(0, 64'h0,                    0, 1, 32'hAAAA0002,  1, 64'h1008,               1, 32'hAAAA0002,  64'h1004,              0, 0);
        v(0, 64'h0,                    0, 1, 32'hAAAA0003,  1, 64'h100C,               1, 32'hAAAA0003,  64'h1008,              0, 0);
        v(0, 64'h0,                    1, 1, 32'h00A00093,  0, 64'h1010,               1, 32'hAAAA0003,  64'h1008,              0, 0); // stall + ack -> BUF
        v(0, 64'h0,                    1, 0, 32'h0,         0, 64'h1010,               1, 32'hAAAA0003,  64'h1008,              0, 0);
        v(0, 64'h0,                    1, 0, 32'h0,         0, 64'h1010,               1, 32'hAAAA0003,  64'h1008,              0, 0);
        v(0, 64'h0,                    0, 0, 32'h0,         1, 64'h1010,               1, 32'h00A00093,  64'h100C,              0, 0); // buffered word out
        v(0, 64'h0,                    0, 0, 32'h0,         1, 64'h1010,               0, 32'h00A00093,  64'h100C,              0, 0); // no ack -> invalid
        v(0, 64'h0,                    0, 1, 32'hBBBB0001,  1, 64'h1014,               1, 32'hBBBB0001,  64'h1010,              0, 0);
        v(1, 64'h2000,                 0, 0, 32'h0,         1, 64'h1014,               0, 32'hBBBB0001,  64'h1010,              1, 0); // redirect, pending -> DISCARD
        v(0, 64'h0,                    0, 0, 32'h0,         1, 64'h1014,               0, 32'hBBBB0001,  64'h1010,              0, 0);
        v(0, 64'h0,                    0, 1, 32'hDEADBEEF,  1, 64'h2000,               0, 32'hBBBB0001,  64'h1010,              0, 0); // stale word dropped
        v(0, 64'h0,                    0, 1, 32'hCCCC0001,  1, 64'h2004,               1, 32'hCCCC0001,  64'h2000,              0, 0);
        v(1, 64'h4000,                 1, 1, 32'hEEEE0001,  1, 64'h4000,               0, 32'hCCCC0001,  64'h2000,              1, 0); // redirect+ack+stall
        v(0, 64'h0,                    0, 1, 32'hCCCC0002,  1, 64'h4004,               1, 32'hCCCC0002,  64'h4000,              0, 0);
        v(1, 64'h3006,                 0, 0, 32'h0,         1, 64'h4004,               0, 32'hCCCC0002,  64'h4000,              1, 1); // misaligned
        v(0, 64'h0,                    0, 1, 32'h12345678,  1, 64'h3004,               0, 32'hCCCC0002,  64'h4000,              0, 0);
        v(0, 64'h0,                    0, 1, 32'hCCCC0003,  1, 64'h3008,               1, 32'hCCCC0003,  64'h3004,              0, 0);
        v(0, 64'h0,                    1, 1, 32'hCCCC0004,  0, 64'h300C,               1, 32'hCCCC0003,  64'h3004,              0, 0); // BUF
        v(1, 64'h5000,                 1, 0, 32'h0,         1, 64'h5000,               0, 32'hCCCC0003,  64'h3004,              1, 0); // redirect in BUF
        v(0, 64'h0,                    0, 0, 32'h0,         1, 64'h5000,               0, 32'hCCCC0003,  64'h3004,              0, 0);
        v(1, 64'hFFFF_FFFF_FFFF_FFFC,  0, 1, 32'h0,         1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'hCCCC0003,  64'h3004,              1, 0);
        v(0, 64'h0,                    0, 1, 32'hCCCC0005,  1, 64'h0,                  1, 32'hCCCC0005,  64'hFFFF_FFFF_FFFF_FFFC, 0, 0); // wrap
        v(0, 64'h0,                    0, 1, 32'hCCCC0006,  1, 64'h4,                  1, 32'hCCCC0006,  64'h0,                 0, 0);
        v(1, 64'h6000,                 0, 0, 32'h0,         1, 64'h4,                  0, 32'hCCCC0006,  64'h0,                 1, 0);
        v(1, 64'h7000,                 0, 0, 32'h0,         1, 64'h4,                  0, 32'hCCCC0006,  64'h0,                 1, 0); // redirect in DISCARD
        v(0, 64'h0,                    0, 1, 32'h0BAD0BAD,  1, 64'h7000,               0, 32'hCCCC0006,  64'h0,                 0, 0);
        v(0, 64'h0,                    0, 1, 32'hCCCC0007,  1, 64'h7004,               1, 32'hCCCC0007,  64'h7000,              0, 0);

        rst_n_in = 1'b0;
        branch_jump_signal_in = 1'b0; target_pc_in = '0; stall_in = 1'b0;
        imem_ack_in = 1'b0; imem_data_in = '0;
        repeat (2) @(posedge clk_in);
        #1 check("reset_state", 0, 64'h1000, 0, 32'h0, 64'h0, 0, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        foreach (vecs[i]) begin
            branch_jump_signal_in = vecs[i].br;
            target_pc_in          = vecs[i].tgt;
            stall_in              = vecs[i].stall;
            imem_ack_in           = vecs[i].ack;
            imem_data_in          = vecs[i].data;
            @(posedge clk_in);
            #1 check($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].vld,
                     vecs[i].instr, vecs[i].ipc, vecs[i].flush, vecs[i].mis);
            @(negedge clk_in);
        end

        // Reset mid-transaction, asynchronous to the clock; acks around it must be ignored.
        branch_jump_signal_in = 1'b0; stall_in = 1'b0; imem_ack_in = 1'b0;
        #2 rst_n_in = 1'b0;
        #1 check("async_reset", 0, 64'h1000, 0, 32'h0, 64'h0, 0, 0);
        imem_ack_in = 1'b1; imem_data_in = 32'hFACEFACE;
        @(posedge clk_in);
        #1 check("reset_hold", 0, 64'h1000, 0, 32'h0, 64'h0, 0, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1 check("post_reset_idle_ack", 1, 64'h1000, 0, 32'h0, 64'h0, 0, 0);
        @(negedge clk_in);
        imem_data_in = 32'h11110000;
        @(posedge clk_in);
        #1 check("post_reset_fetch", 1, 64'h1004, 1, 32'h11110000, 64'h1000, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
FETCH_REDIRECT_UNIT -- requirements
Module: fetch_redirect_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC loaded on reset.
REQ-002 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n_in, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port branch_jump_signal_in, input, 1, taken branch/jump redirect request from the execute stage.
REQ-005 SHALL have port target_pc_in, input, 64, redirect target; sampled only when branch_jump_signal_in=1.
REQ-006 SHALL have port stall_in, input, 1, hazard hold from decode.
REQ-007 SHALL have port imem_req_out, output, 1, instruction memory request.
REQ-008 SHALL have port imem_addr_out, output, 64, fetch address.
REQ-009 SHALL have port imem_ack_in, input, 1, memory completion; one per request.
REQ-010 SHALL have port imem_data_in, input, 32, instruction word, valid when imem_ack_in=1.
REQ-011 SHALL have ports instr_out (output, 32), instr_pc_out (output, 64) and instr_valid_out (output, 1), the registered instruction to decode.
REQ-012 SHALL have port flush_out, output, 1, one-cycle kill pulse for the IF/ID and ID/EX registers.
REQ-013 SHALL have port misaligned_out, output, 1, one-cycle pulse on a redirect target with target_pc_in[1:0] != 0.

Function
REQ-014 SHALL implement states IDLE, REQ, BUF and DISCARD; IDLE is entered only from reset.
REQ-015 SHALL go IDLE->REQ unconditionally on the first clock after reset release, with imem_req_out=0 in IDLE.
REQ-016 SHALL drive imem_req_out=1 in REQ and DISCARD, holding imem_addr_out=pc_reg stable until imem_ack_in=1; at most one request outstanding.
REQ-017 SHALL, in REQ on imem_ack_in=1 with stall_in=0 and no redirect, register instr_out=imem_data_in, instr_pc_out=pc_reg and instr_valid_out=1, advance pc_reg by 4, and stay in REQ, giving one instruction per cycle on single-cycle ack.
REQ-018 SHALL, in REQ on imem_ack_in=1 with stall_in=1, capture the word and its PC into a one-entry buffer, advance pc_reg by 4, and go to BUF.
REQ-019 SHALL, while stall_in=1, hold instr_out, instr_pc_out and instr_valid_out unchanged, and deassert imem_req_out in BUF.
REQ-020 SHALL, in BUF with stall_in=0, move the buffered word to the outputs with instr_valid_out=1 and return to REQ.
REQ-021 SHALL, in REQ when no ack arrives and stall_in=0, drive instr_valid_out=0 on the next cycle.
REQ-022 SHALL give redirect priority over stall and ack: on branch_jump_signal_in=1, set pc_reg={target_pc_in[63:2],2'b00}, clear instr_valid_out and the buffer, and pulse flush_out=1 on the next cycle.
REQ-023 SHALL, on redirect in REQ without ack the same cycle, go to DISCARD, keep the old request high until its ack, drop that data, then go to REQ issuing the new address.
REQ-024 SHALL, on redirect coinciding with imem_ack_in=1 in REQ, drop the returned word and go directly to REQ with the new address on the next cycle.
REQ-025 SHALL, on redirect in BUF or DISCARD, go to REQ or stay in DISCARD respectively, discarding buffered or pending data.
REQ-026 SHALL pulse misaligned_out=1 in the same cycle as flush_out when target_pc_in[1:0] != 0.
REQ-027 SHALL compute pc_reg+4 modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.

Reset
REQ-028 SHALL, while rst_n_in=0 and independent of clock, force state=IDLE, pc_reg=RESET_PC, and all outputs to 0 except imem_addr_out=RESET_PC.
REQ-029 SHALL, on reset assertion mid-transaction, abandon any outstanding request and ignore acks until the next REQ.

Verification
REQ-030 SHALL cover: reset release with RESET_PC=0x1000 and ack every cycle -> instr_pc_out sequence 0x1000, 0x1004, 0x1008 with instr_valid_out=1 from cycle 3.
REQ-031 SHALL cover: stall_in=1 for 3 cycles while an ack returns 0x00A00093 -> outputs held; word appears exactly one cycle after stall_in falls; no instruction lost or duplicated.
REQ-032 SHALL cover: redirect to 0x2000 while a request is pending, ack 2 cycles later -> flush_out pulses once, stale word dropped, next imem_addr_out=0x2000.
REQ-033 SHALL cover: redirect coinciding with ack and stall_in=1 -> word dropped, flush_out=1 next cycle, fetch resumes at target.
REQ-034 SHALL cover: redirect target 0x3006 -> pc_reg=0x3004, misaligned_out=1 for one cycle; and pc_reg=64'hFFFF_FFFF_FFFF_FFFC with ack -> next fetch address 0.
